// File: rtl/mem_instrucao_prog.sv
// Loadable instruction memory for the nRisc fetch stage: word-wide programming port with LOAD/RUN mode FSM, registered fetch port.
// Define MEM_INSTR_PARITY_EN to store an even-parity bit per word and flag mismatches on fetch.
module mem_instrucao_prog #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic [ADDR_W:0]   prog_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
`ifdef MEM_INSTR_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   wr_word;
  logic [WORD_W-1:0]   rd_word;
  logic                transfer;
  logic                fetch_do;

  assign prog_ready = (state_q == LOAD);
  assign busy       = (state_q != RUN);
  assign transfer   = prog_valid && prog_ready;
  assign fetch_do   = fetch_en && (state_q == RUN);
  assign rd_word    = mem_q[endereco];

`ifdef MEM_INSTR_PARITY_EN
  assign wr_word = {^prog_data, prog_data};
`else
  assign wr_word = prog_data;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    case (state_q)
      IDLE: if (prog_start) state_d = LOAD;
      LOAD: begin
        if (transfer) begin
          // A full memory ends the load even without prog_last; the address never wraps.
          if (prog_last || addr_q == LAST_ADDR) state_d = RUN;
          else                                  addr_d  = addr_q + 1'b1;
          if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
        end
      end
      RUN: if (prog_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD && state_q != LOAD) begin
      addr_d  = '0;
      count_d = '0;
    end
    if (fetch_do) begin
      instr_d       = rd_word[DATA_W-1:0];
      instr_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Storage array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (transfer) mem_q[addr_q] <= wr_word;
  end

`ifdef MEM_INSTR_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q;
    if (fetch_do) parity_err_d = (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) parity_err_q <= 1'b0;
    else          parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign prog_count  = count_q;

endmodule

// File: doc/mem_instrucao_prog.md
Name: mem_instrucao_prog

Overview:
- Parametrised, loadable instruction memory for the nRisc datapath; next generation of the combinational instruction ROM.
- Adds a word-wide programming port with valid/ready handshake and a LOAD/RUN mode FSM.
- Adds a registered (1-cycle) fetch port with valid flag.
- Sits between the boot loader (host/UART side) and the PC/fetch stage; replaces file-preloaded memory.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words

Ports:
clock  input  1  single clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
prog_start  input  1  request to (re)enter LOAD mode
prog_valid  input  1  prog_data holds a word to write
prog_data  input  DATA_W  word to store at current load address
prog_last  input  1  marks final word of the program (qualified by prog_valid)
prog_ready  output  1  memory accepts a program word this cycle
prog_count  output  ADDR_W+1  number of words written in current/last load
fetch_en  input  1  fetch request, honoured only in RUN
endereco  input  ADDR_W  fetch address (PC)
instr  output  DATA_W  fetched instruction, registered
instr_valid  output  1  instr updated by a fetch issued the previous cycle
busy  output  1  high while not in RUN (core must stall)
parity_err  output  1  read parity mismatch (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; instr=0, instr_valid=0, prog_ready=0, prog_count=0, busy=1, parity_err=0. Memory array is NOT cleared.
- States: IDLE, LOAD, RUN. busy = (state != RUN).
- IDLE: prog_start -> LOAD next cycle. fetch_en ignored.
- Entering LOAD: load address and prog_count cleared to 0 in the same edge that changes state.
- LOAD: prog_ready=1. Transfer = prog_valid & prog_ready at a rising edge: mem[addr] <= prog_data, addr++, prog_count++.
- LOAD exit: transfer with prog_last=1, OR transfer at addr=DEPTH-1 (memory full) -> RUN next cycle; prog_ready=0 from that cycle. Full wins regardless of prog_last; addr never wraps, so no over-write of word 0.
- prog_start in LOAD: ignored. prog_valid outside LOAD: ignored, no write.
- RUN: prog_start -> LOAD (reload). fetch_en at edge N: instr <= mem[endereco], instr_valid=1 after edge N; instr_valid=0 after any edge without fetch_en; instr holds last value.
- prog_start and fetch_en together in RUN: fetch is served (instr/instr_valid updated), state goes to LOAD.
- Outside RUN: instr_valid forced 0, instr holds.
- prog_count saturates at DEPTH (ADDR_W+1 bits, no overflow); holds after LOAD until next LOAD entry.
- Reset mid-LOAD: aborts immediately; words already written remain; returns to IDLE.

Optional Feature:
- Macro MEM_INSTR_PARITY_EN.
- Defined: each word stores an extra even-parity bit computed at write. On fetch, parity_err is registered alongside instr; it is 1 when the stored bit != XOR of the stored data, and updates only on fetch.
- Undefined: no parity storage; parity_err tied 0. Port list is identical either way.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> immediately instr=0, instr_valid=0, busy=1, prog_ready=0; fetch_en=1 in IDLE -> instr_valid stays 0.
- Load 3 words: prog_start, then write 0x11, 0x22, 0x33 (last on 0x33) with a prog_valid gap between 0x22 and 0x33 -> prog_count=3, RUN one cycle after last, busy=0.
- Fetch: in RUN, fetch_en=1 endereco=2 -> next cycle instr=0x33, instr_valid=1; fetch_en=0 -> instr_valid=0, instr stays 0x33.
- Full memory: ADDR_W=2, stream 4 words without prog_last -> RUN after 4th, prog_count=4, prog_ready=0; 5th prog_valid is not written, so mem[0] is unchanged.
- Reload/abort: in RUN, prog_start plus fetch_en -> fetch served, LOAD entered with prog_count=0; assert reset_n=0 after 1 word -> IDLE, word 0 new, word 1 old.
- Parity (MEM_INSTR_PARITY_EN): force a stored data bit flip via hierarchical write, fetch that address -> parity_err=1; fetch a clean word -> parity_err=0; with the macro undefined, parity_err stays 0.
